// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls and ID-resolved branch flushes for the 5-stage core.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module hazard_ctrl #(
  parameter int unsigned LU_STALL = 1,
  parameter int unsigned BR_FLUSH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       br_taken,
  output logic       pc_write,
  output logic       ifid_hold,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

  state_e     r_state;
  state_e     w_state_d;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_d;
  logic       w_lu;

  // $0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign w_lu = ex_memread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StRun;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    busy        = 1'b0;
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_lu) begin
            pc_write    = 1'b0;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            if (LU_STALL > 1) begin
              w_state_d = StStall;
              w_cnt_d   = 3'(LU_STALL - 1);
            end
          end else if (br_taken) begin
            ifid_flush = 1'b1;
            if (BR_FLUSH > 1) begin
              w_state_d = StFlush;
              w_cnt_d   = 3'(BR_FLUSH - 1);
            end
          end
        end
        StStall: begin
          pc_write    = 1'b0;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          busy        = 1'b1;
          if (r_cnt <= 3'd1) begin
            w_state_d = StRun;
            w_cnt_d   = 3'd0;
          end else begin
            w_cnt_d = r_cnt - 3'd1;
          end
        end
        StFlush: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          busy        = 1'b1;
          if (r_cnt <= 3'd1) begin
            w_state_d = StRun;
            w_cnt_d   = 3'd0;
          end else begin
            w_cnt_d = r_cnt - 3'd1;
          end
        end
        default: begin
          w_state_d = StRun;
          w_cnt_d   = 3'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (ifid_hold && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (ifid_flush && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: instance A uses LU_STALL=1/BR_FLUSH=1, instance B 3/2.
// Output vector order: {pc_write, ifid_hold, ifid_flush, idex_bubble, busy}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, br_taken;

  logic a_pc, a_hold, a_flush, a_bub, a_busy;
  logic b_pc, b_hold, b_flush, b_bub, b_busy;
`ifdef HAZARD_STATS_EN
  logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_STALL(1), .BR_FLUSH(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .br_taken(br_taken),
    .pc_write(a_pc), .ifid_hold(a_hold), .ifid_flush(a_flush), .idex_bubble(a_bub),
    .busy(a_busy)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
`endif
  );

  hazard_ctrl #(.LU_STALL(3), .BR_FLUSH(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .br_taken(br_taken),
    .pc_write(b_pc), .ifid_hold(b_hold), .ifid_flush(b_flush), .idex_bubble(b_bub),
    .busy(b_busy)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
`endif
  );

  typedef struct {
    string       name;
    logic [4:0]  ea;
    logic [4:0]  eb;
    bit          chk;
    logic [15:0] es;
    logic [15:0] ef;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [4:0] RST  = 5'b00110;
  localparam logic [4:0] OK   = 5'b10000;
  localparam logic [4:0] LU   = 5'b01010;
  localparam logic [4:0] STL  = 5'b01011;
  localparam logic [4:0] BR   = 5'b10100;
  localparam logic [4:0] FLS  = 5'b10111;

  task automatic cyc(input string name, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ut, input logic mr, input logic [4:0] ert, input logic br,
                     input logic [4:0] ea, input logic [4:0] eb, input bit chk = 1'b0,
                     input logic [15:0] es = 16'd0, input logic [15:0] ef = 16'd0);
    exp_t e;
    rst_n = r; id_rs = rs; id_rt = rt; id_uses_rt = ut;
    ex_memread = mr; ex_rt = ert; br_taken = br;
    e.name = name; e.ea = ea; e.eb = eb; e.chk = chk; e.es = es; e.ef = ef;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [4:0] wa, wb;
      e  = q.pop_front();
      wa = {a_pc, a_hold, a_flush, a_bub, a_busy};
      wb = {b_pc, b_hold, b_flush, b_bub, b_busy};
      n_cmp++;
      if (wa !== e.ea) begin
        n_bad++;
        $display("FAIL %s dut_a: got %b expected %b", e.name, wa, e.ea);
      end
      n_cmp++;
      if (wb !== e.eb) begin
        n_bad++;
        $display("FAIL %s dut_b: got %b expected %b", e.name, wb, e.eb);
      end
      n_cmp++;
      if ((a_hold & a_flush) | (b_hold & b_flush)) begin
        n_bad++;
        $display("FAIL %s hold_flush_excl: got a=%b%b b=%b%b expected not both set", e.name,
                 a_hold, a_flush, b_hold, b_flush);
      end
`ifdef HAZARD_STATS_EN
      if (e.chk) begin
        n_cmp++;
        if (b_scnt !== e.es || b_fcnt !== e.ef) begin
          n_bad++;
          $display("FAIL %s stats: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   e.name, b_scnt, b_fcnt, e.es, e.ef);
        end
      end
`endif
    end
  end

  initial begin
    rst_n = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_rt = '0; br_taken = 1'b0;
    @(posedge clk);
    #1;
    // Reset with random inputs.
    cyc("reset1", 0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
        1'($urandom), RST, RST);
    cyc("reset2", 0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
        1'($urandom), RST, RST);
    cyc("release", 1, 0, 0, 0, 0, 0, 0, OK, OK);
    // Load-use on rs.
    cyc("lu_rs", 1, 8, 0, 0, 1, 8, 0, LU, LU);
    cyc("lu_c2", 1, 0, 0, 0, 0, 0, 0, OK, STL);
    cyc("lu_c3", 1, 0, 0, 0, 0, 0, 0, OK, STL);
    cyc("lu_done", 1, 0, 0, 0, 0, 0, 0, OK, OK);
    // $0 and rt gating.
    cyc("zero_reg", 1, 0, 0, 1, 1, 0, 0, OK, OK);
    cyc("rt_unused", 1, 3, 9, 0, 1, 9, 0, OK, OK);
    cyc("rt_used", 1, 3, 9, 1, 1, 9, 0, LU, LU);
    cyc("rt_c2", 1, 0, 0, 0, 0, 0, 0, OK, STL);
    cyc("rt_c3", 1, 0, 0, 0, 0, 0, 0, OK, STL);
    // Branch flush.
    cyc("br", 1, 0, 0, 0, 0, 0, 1, BR, BR);
    cyc("br_c2", 1, 0, 0, 0, 0, 0, 0, OK, FLS);
    cyc("br_done", 1, 0, 0, 0, 0, 0, 0, OK, OK);
    // Simultaneous lu and br: stall wins, held branch flushes after the stall.
    cyc("lu_br", 1, 8, 0, 0, 1, 8, 1, LU, LU);
    cyc("brh_c2", 1, 8, 0, 0, 0, 8, 1, BR, STL);
    cyc("brh_c3", 1, 8, 0, 0, 0, 8, 1, BR, STL);
    cyc("brh_fl1", 1, 8, 0, 0, 0, 8, 1, BR, BR);
    cyc("brh_fl2", 1, 0, 0, 0, 0, 0, 0, OK, FLS);
    cyc("brh_done", 1, 0, 0, 0, 0, 0, 0, OK, OK);
    // Back-to-back stalls; lu is ignored inside STALL.
    cyc("b2b_1", 1, 8, 0, 0, 1, 8, 0, LU, LU);
    cyc("b2b_c2", 1, 0, 0, 0, 0, 0, 0, OK, STL);
    cyc("b2b_c3", 1, 8, 0, 0, 1, 8, 0, LU, STL);
    cyc("b2b_2", 1, 8, 0, 0, 1, 8, 0, LU, LU);
    cyc("b2b_2c2", 1, 0, 0, 0, 0, 0, 0, OK, STL);
    cyc("b2b_2c3", 1, 0, 0, 0, 0, 0, 0, OK, STL);
    cyc("b2b_done", 1, 0, 0, 0, 0, 0, 0, OK, OK);
    // Reset in the 2nd stall cycle abandons the stall.
    cyc("rs_lu", 1, 8, 0, 0, 1, 8, 0, LU, LU);
    cyc("rs_mid", 0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
        1'($urandom), RST, RST);
    cyc("rs_after", 1, 0, 0, 0, 0, 0, 0, OK, OK, 1'b1, 16'd0, 16'd0);
    cyc("fresh_lu", 1, 8, 0, 0, 1, 8, 0, LU, LU, 1'b1, 16'd0, 16'd0);
    cyc("fresh_c2", 1, 0, 0, 0, 0, 0, 0, OK, STL, 1'b1, 16'd1, 16'd0);
    cyc("fresh_c3", 1, 0, 0, 0, 0, 0, 0, OK, STL, 1'b1, 16'd2, 16'd0);
    cyc("fresh_done", 1, 0, 0, 0, 0, 0, 0, OK, OK, 1'b1, 16'd3, 16'd0);
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core. Sequences the IF/ID register, PC write and ID/EX bubble insertion. Detects load-use hazards (stall) and taken branches/jumps resolved in ID (flush). Stall and flush lengths are configurable, and a small FSM holds multi-cycle stalls and flushes.

Parameters:
LU_STALL, 1, load-use stall length in cycles (legal 1..7)
BR_FLUSH, 1, branch/jump flush length in cycles (legal 1..7)

Ports:
clk  input  1  core clock; all state updates on posedge
rst_n  input  1  synchronous active-low reset
id_rs  input  5  rs field of the instruction in IF/ID
id_rt  input  5  rt field of the instruction in IF/ID
id_uses_rt  input  1  IF/ID instruction reads rt as a source
ex_memread  input  1  ID/EX instruction is a load
ex_rt  input  5  destination rt of the ID/EX load
br_taken  input  1  branch taken or jump, resolved in ID this cycle
pc_write  output  1  PC register load enable
ifid_hold  output  1  IF/ID keeps its contents
ifid_flush  output  1  IF/ID loads a nop (0x00000000)
idex_bubble  output  1  ID/EX control signals zeroed
busy  output  1  FSM not in RUN

Behaviour:
- Reset is synchronous and active-low. The clock port is clk and the reset port is rst_n.
- While rst_n=0 (outputs forced combinationally): pc_write=0, ifid_hold=0, ifid_flush=1, idex_bubble=1, busy=0.
- At the first posedge with rst_n=0: state<=RUN, cnt<=0.
- Hazard term: lu = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)). Register $0 never causes a hazard.
- States: RUN, STALL, FLUSH (2-bit encoding). cnt is 3 bits.
- Outputs are combinational from state and inputs, so a hazard acts in the same cycle it is detected. There is no added latency.
- RUN, lu=1 (highest priority; br_taken ignored this cycle):
  - Outputs: pc_write=0, ifid_hold=1, idex_bubble=1, ifid_flush=0.
  - If LU_STALL>1: next state STALL, cnt<=LU_STALL-1. Otherwise stay in RUN.
- RUN, lu=0, br_taken=1:
  - Outputs: pc_write=1 (PC loads target), ifid_flush=1, ifid_hold=0, idex_bubble=0.
  - If BR_FLUSH>1: next state FLUSH, cnt<=BR_FLUSH-1.
- RUN, neither: pc_write=1, all others 0.
- STALL:
  - Outputs identical to the RUN/lu case. lu and br_taken are ignored.
  - cnt decrements each cycle. When cnt==1, next state is RUN, so the stall totals exactly LU_STALL cycles.
  - After return to RUN, the branch is re-evaluated using the now-valid operands.
- FLUSH:
  - Outputs: pc_write=1, ifid_flush=1, idex_bubble=1, ifid_hold=0. lu and br_taken are ignored because the IF/ID contents are invalid.
  - cnt decrements; cnt==1 leads to RUN. Total flush is BR_FLUSH cycles.
- busy=1 in STALL or FLUSH.
- Invariant: ifid_hold and ifid_flush are never both 1.
- Back-to-back: a new lu in the first RUN cycle after STALL starts a new stall immediately.
- Reset mid-STALL/FLUSH: next cycle state=RUN, cnt=0. The partial sequence is abandoned.
- X on inputs during reset must not propagate to outputs.

Optional Feature:
HAZARD_STATS_EN
- Defined: adds output ports stall_cnt [15:0] and flush_cnt [15:0].
  - stall_cnt increments each cycle ifid_hold=1; flush_cnt increments each cycle ifid_flush=1 with rst_n=1.
  - Both saturate at 16'hFFFF and clear to 0 on reset.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> pc_write=0, ifid_flush=1, idex_bubble=1, busy=0; first cycle after release with no hazard -> pc_write=1.
- Load-use, LU_STALL=1: ex_memread=1, ex_rt=8, id_rs=8 for one cycle -> that cycle pc_write=0, ifid_hold=1, idex_bubble=1; next cycle (ex_memread=0) all clear.
- $0 and rt gating: ex_rt=0=id_rs -> no stall. ex_rt=9=id_rt with id_uses_rt=0 -> no stall; with id_uses_rt=1 -> stall.
- Multi-cycle, LU_STALL=3 and BR_FLUSH=2:
  - lu pulse -> ifid_hold=1 for exactly 3 cycles, busy=1 in cycles 2-3.
  - br_taken pulse -> ifid_flush=1 for 2 cycles, idex_bubble=1 in cycle 2 only.
- Simultaneous lu and br_taken in RUN -> stall wins: ifid_flush=0, pc_write=0. br_taken held -> flush begins the cycle after the stall ends.
- Reset in the 2nd STALL cycle (LU_STALL=3) -> following cycle busy=0; with HAZARD_STATS_EN, stall_cnt=0 after reset, and counts 3 after a fresh full stall.
